// File: rtl/i2s_tx_fifo.sv
// i2s_tx_fifo: stereo-frame FIFO feeding an I2S / left-justified serialiser (`define I2S_HOLD_LAST_EN replays the last frame on underrun).
// Latency: a frame written to an empty FIFO starts at the next frame boundary, fetched on the last bit of the current frame.
// Backpressure: full flags the FIFO; writes while full are dropped, and an empty fetch sends filler and pulses underrun.
module i2s_tx_fifo #(
    parameter int SAMPLE_W   = 24,
    parameter int SLOT_W     = 25,
    parameter int BCLK_DIV   = 50,
    parameter int FIFO_DEPTH = 8,
    parameter int FMT_LJ     = 0
) (
    input  logic                          clk_soc,
    input  logic                          reset,
    input  logic [2*SAMPLE_W-1:0]         frame_in,
    input  logic                          write_frame,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          underrun,
    output logic                          bclk,
    output logic                          lrclk,
    output logic                          sdata
);
    localparam int FRAME_W = 2 * SAMPLE_W;
    localparam int CNT_W   = $clog2(BCLK_DIV);
    localparam int BIT_W   = $clog2(2 * SLOT_W);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int SEL_W   = $clog2(FRAME_W);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BCLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(BCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2 * SLOT_W - 1);
    localparam logic [BIT_W-1:0] SLOT_LEN  = BIT_W'(SLOT_W);
    localparam logic [BIT_W-1:0] SLOT_PRE  = BIT_W'(SLOT_W - 1);
    localparam logic [BIT_W-1:0] SAMP_LEN  = BIT_W'(SAMPLE_W);
    localparam logic             LRCLK_RST = (FMT_LJ == 0);

    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [BIT_W-1:0]   bit_idx, bit_nxt, slot_nxt;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   lvl_nxt;
    logic [FRAME_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [FRAME_W-1:0] shreg, frame_nxt, fill;
    logic [SEL_W-1:0]   sel;
    logic               wrap, fetch, push, pop;
    logic               right_nxt, lrclk_nxt, sdata_nxt;

    assign wrap  = (cnt == CNT_LAST);
    assign fetch = wrap && (bit_idx == BIT_LAST);
    // A full FIFO refuses writes even when the same cycle pops.
    assign push  = write_frame && !full;
    assign pop   = fetch && !empty;

`ifdef I2S_HOLD_LAST_EN
    logic [FRAME_W-1:0] last_frame;

    always_ff @(posedge clk_soc or posedge reset) begin
        if (reset) begin
            last_frame <= '0;
        end else if (pop) begin
            last_frame <= fifo_mem[rd_ptr];
        end
    end

    assign fill = last_frame;
`else
    assign fill = '0;
`endif

    always_comb begin
        cnt_nxt = wrap ? '0 : cnt + 1'b1;
        bit_nxt = bit_idx;
        if (wrap) begin
            bit_nxt = (bit_idx == BIT_LAST) ? '0 : bit_idx + 1'b1;
        end
        right_nxt = (bit_nxt >= SLOT_LEN);
        slot_nxt  = right_nxt ? bit_nxt - SLOT_LEN : bit_nxt;
        // I2S raises word select on the last bit of the left slot.
        lrclk_nxt = (FMT_LJ != 0) ? right_nxt : (bit_nxt >= SLOT_PRE);
        frame_nxt = shreg;
        if (fetch) begin
            frame_nxt = pop ? fifo_mem[rd_ptr] : fill;
        end
        sel       = '0;
        sdata_nxt = 1'b0;
        if (slot_nxt < SAMP_LEN) begin
            sel       = SEL_W'(SAMPLE_W - 1 - int'(slot_nxt) + (right_nxt ? 0 : SAMPLE_W));
            sdata_nxt = frame_nxt[sel];
        end
        lvl_nxt = level + LVL_W'(push) - LVL_W'(pop);
    end

    always_ff @(posedge clk_soc or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            bit_idx  <= '0;
            bclk     <= 1'b0;
            lrclk    <= LRCLK_RST;
            sdata    <= 1'b0;
            shreg    <= '0;
            underrun <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            cnt      <= cnt_nxt;
            bit_idx  <= bit_nxt;
            bclk     <= (cnt_nxt >= CNT_HALF);
            underrun <= fetch && empty;
            if (wrap) begin
                lrclk <= lrclk_nxt;
                sdata <= sdata_nxt;
            end
            if (fetch) begin
                shreg <= frame_nxt;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= lvl_nxt;
            full  <= (lvl_nxt == LVL_W'(FIFO_DEPTH));
            empty <= (lvl_nxt == '0);
        end
    end

    always_ff @(posedge clk_soc) begin
        if (push) begin
            fifo_mem[wr_ptr] <= frame_in;
        end
    end
endmodule
